// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant held through a
// valid/ready handshake, pointer advancing once per completed transfer.

module pry2oht #(
   parameter int    WIDTH          = 4,
   parameter int    SPLIT          = 2,
   parameter int    IMPLEMENTATION = 0,
   parameter string DIRECTION      = "LSB"
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [WIDTH-1:0] o_oht
);

   logic [WIDTH-1:0] w_in;
   logic [WIDTH-1:0] w_out;

   genvar g;

   generate
      if (DIRECTION == "MSB") begin : g_rev
         for (g = 0; g < WIDTH; g++) begin : g_bit
            assign w_in[g]  = i_vec[WIDTH-1-g];
            assign o_oht[g] = w_out[WIDTH-1-g];
         end
      end else begin : g_fwd
         assign w_in  = i_vec;
         assign o_oht = w_out;
      end

      // Both forms gate a bit only by the bits below it, so X above the
      // winner is forced to 0 by the AND rather than leaking through.
      if (IMPLEMENTATION == 0 || SPLIT < 2) begin : g_ripple
         logic [WIDTH-1:0] w_seen;
         for (g = 0; g < WIDTH; g++) begin : g_bit
            if (g == 0) begin : g_first
               assign w_seen[g] = 1'b0;
            end else begin : g_rest
               assign w_seen[g] = w_seen[g-1] | w_in[g-1];
            end
            assign w_out[g] = w_in[g] & ~w_seen[g];
         end
      end else begin : g_masked
         for (g = 0; g < WIDTH; g++) begin : g_bit
            localparam logic [WIDTH-1:0] LO = (WIDTH'(1) << g) - WIDTH'(1);
            assign w_out[g] = w_in[g] & ~|(w_in & LO);
         end
      end
   endgenerate

endmodule

module rr_arbiter #(
   parameter int WIDTH          = 4,
   parameter int SPLIT          = 2,
   parameter int IMPLEMENTATION = 0,
   localparam int IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   input  logic             gnt_rdy,
   input  logic             gnt_lst
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam logic [WIDTH-1:0] PTR_RST = WIDTH'(1) << (WIDTH - 1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_ptr;
   logic [WIDTH-1:0] r_gnt;
   logic [IDX_W-1:0] r_idx;

   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_req_msk;
   logic [WIDTH-1:0] w_msk_oht;
   logic [WIDTH-1:0] w_raw_oht;
   logic [WIDTH-1:0] w_sel;
   logic [IDX_W-1:0] w_idx;
   logic             w_done;

   // On completion the mask follows the current grant, which is the value
   // the pointer is about to take, so re-arbitration needs no extra cycle.
   assign w_base    = (r_state == GRANT) ? r_gnt : r_ptr;
   assign w_mask    = ~((w_base << 1) - WIDTH'(1));
   assign w_req_msk = req & w_mask;

   pry2oht #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION),
      .DIRECTION      ("LSB")
   ) u_msk (
      .i_vec (w_req_msk),
      .o_oht (w_msk_oht)
   );

   pry2oht #(
      .WIDTH          (WIDTH),
      .SPLIT          (SPLIT),
      .IMPLEMENTATION (IMPLEMENTATION),
      .DIRECTION      ("LSB")
   ) u_raw (
      .i_vec (req),
      .o_oht (w_raw_oht)
   );

   assign w_sel = (|w_req_msk) ? w_msk_oht : w_raw_oht;

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_sel[i]) w_idx = w_idx | IDX_W'(i);
      end
   end

   assign w_done = (r_state == GRANT) & gnt_rdy & gnt_lst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= PTR_RST;
         r_gnt   <= '0;
         r_idx   <= '0;
      end else if (r_state == IDLE) begin
         if (|req) begin
            r_gnt   <= w_sel;
            r_idx   <= w_idx;
            r_state <= GRANT;
         end
      end else if (w_done) begin
         r_ptr <= r_gnt;
         if (|req) begin
            r_gnt <= w_sel;
            r_idx <= w_idx;
         end else begin
            r_gnt   <= '0;
            r_idx   <= '0;
            r_state <= IDLE;
         end
      end
   end

   assign gnt     = r_gnt;
   assign gnt_idx = r_idx;
   assign gnt_vld = (r_state == GRANT);

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource between WIDTH requesters.
- Arbitration uses rotating-priority selection: a masked and an unmasked rightmost-priority pick, built on pry2oht (DIRECTION "LSB").
- Grant is registered, held stable through a valid/ready handshake, and may span multi-beat transfers terminated by a last flag.
- The pointer advances only on transfer completion, so fairness is per transfer, not per beat.

Parameters:
- WIDTH, 4, number of requesters (>=1).
- SPLIT, 2, passed to the internal pry2oht instances.
- IMPLEMENTATION, 0, passed to the internal pry2oht instances; the block's behaviour is independent of this value.
- IDX_W, (WIDTH>1 ? $clog2(WIDTH) : 1), width of the binary grant index (localparam).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  WIDTH  request vector; bit i = requester i.
- gnt  output  WIDTH  registered one-hot grant; all zeros when idle.
- gnt_idx  output  IDX_W  binary index of the set gnt bit; 0 when idle.
- gnt_vld  output  1  a grant is active (equals |gnt).
- gnt_rdy  input  1  downstream accepts the current beat.
- gnt_lst  input  1  current beat is the last of the transfer; qualified by gnt_vld & gnt_rdy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt=0, gnt_idx=0, gnt_vld=0, state=IDLE.
  - ptr=one-hot bit WIDTH-1, so the first arbitration after reset favours bit 0.
- Selection (combinational, every cycle):
  - mask = bits strictly above the set ptr bit.
  - msk_oht = pry2oht(req & mask); raw_oht = pry2oht(req).
  - sel = msk_oht if |(req & mask), else raw_oht.
  - Result: the lowest requesting bit above ptr wins; otherwise wrap to the lowest requesting bit overall.
- State IDLE (gnt_vld=0):
  - If |req: gnt<=sel, gnt_idx<=index(sel), go to GRANT.
  - Latency: req asserted in cycle N gives gnt_vld=1 in cycle N+1.
  - If req=0: remain in IDLE.
- State GRANT (gnt_vld=1):
  - gnt and gnt_idx are held constant.
  - Beat without completion (gnt_rdy & ~gnt_lst): no change.
  - gnt_rdy=0: no change; gnt_lst is ignored.
- Completion (gnt_rdy & gnt_lst in GRANT):
  - ptr<=gnt.
  - Same-cycle re-arbitration: sel is computed with mask derived from the current gnt (the value ptr is being loaded with), against the current-cycle req.
  - If |req: gnt<=sel, stay in GRANT. Back-to-back transfers, no bubble.
  - Else: gnt<=0, gnt_idx<=0, go to IDLE.
  - The completing requester may win again only if it is the sole requester.
- Withdrawn request: if the granted requester deasserts req during GRANT, the grant is not withdrawn. Requesters hold req until completion; violation is a protocol error that the block does not detect.
- New requests arriving mid-transfer have no effect until completion.
- WIDTH=1:
  - gnt mirrors req with 1-cycle latency.
  - gnt is held until completion.
  - gnt_idx is constant 0.
- Reset asserted mid-transfer:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - ptr returns to bit WIDTH-1.
  - No partial state survives.
- X on req bits other than the selected bit must not propagate to gnt. The chosen pry2oht IMPLEMENTATION is responsible for this.
- gnt is always one-hot or zero; gnt_idx is always consistent with gnt.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, req=0 -> gnt=0000, gnt_vld=0, gnt_idx=0; outputs clear asynchronously on rst_n fall mid-grant.
2. Single requester: req=0100 at cycle N -> gnt=0100, gnt_idx=2, gnt_vld=1 at N+1. Hold gnt_rdy=0 for 3 cycles -> gnt unchanged. gnt_rdy=1, gnt_lst=1 -> next cycle gnt=0100 again if req held; gnt=0 if req dropped.
3. Round-robin fairness: req=1111 constant, every beat gnt_rdy=gnt_lst=1 -> grant sequence 0001, 0010, 0100, 1000, 0001..., with gnt_vld continuously 1 (no bubbles).
4. Multi-beat lock: req=0011, granted 0001; 3 beats with gnt_lst=0, then gnt_lst=1 -> gnt stays 0001 for all 4 beats, then 0010. Raising req bit 3 mid-transfer does not change gnt.
5. Wrap and skip: ptr at 0100 (after granting bit 2), req=0011 -> next gnt=0001 (wrap). Then req=1001 with ptr=0001 -> gnt=1000.
6. Sparse/exhaustive: for all 16 req values, held from an idle start with single-beat completion -> gnt always one-hot or zero, gnt_idx matches, and no requester is skipped within WIDTH completions.
